// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory-port arbiter.
// Contents: arbiter FSM state enum, MUX select encodings and default widths/limits.
package mem_arb_pkg;

  localparam int unsigned DEF_AW            = 32;
  localparam int unsigned DEF_DW            = 32;
  localparam int unsigned DEF_MAX_DM_STREAK = 4;
  localparam int unsigned DEF_TIMEOUT       = 64;

  // External address/data MUX select encodings
  localparam logic SEL_IF = 1'b0;
  localparam logic SEL_DM = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StBusyIf,
    StBusyDm
  } arb_state_e;

endpackage

// File: rtl/arb_watchdog.sv
// Transaction watchdog for mem_port_arbiter. Built only when ARB_TIMEOUT_EN is defined.
// Ports:
//   i_clk, i_rst  clock and synchronous active-high reset
//   i_busy        arbiter has a transaction outstanding
//   i_ack         memory acknowledge for the outstanding transaction
//   o_timeout     TIMEOUT busy cycles elapsed without i_ack; abort this cycle
`ifdef ARB_TIMEOUT_EN
module arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_busy,
  input  logic i_ack,
  output logic o_timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  // r_cnt holds the number of busy cycles already completed, so the abort
  // fires during the TIMEOUT-th busy cycle.
  assign o_timeout = i_busy & ~i_ack & (r_cnt == LAST_CNT);

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_busy || i_ack || o_timeout) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one unified memory port between the IF and DM pipeline stages.
// DM wins simultaneous requests until MAX_DM_STREAK consecutive DM grants have
// been made while IF waited; IF is then served once. Address, write data and
// write enable are latched at grant and held until mem_ack.
// Optional watchdog: define ARB_TIMEOUT_EN to abort transactions after TIMEOUT
// cycles without mem_ack (valid pulses with zero data, sticky err).
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_if_req/i_if_addr                IF request; o_if_valid/o_if_rdata response
//   i_dm_req/we/addr/wdata            DM request; o_dm_valid/o_dm_rdata response
//   o_if_stall, o_dm_stall            per-stage stalls (req & ~valid)
//   o_sel                             external MUX select (0 = IF, 1 = DM)
//   o_mem_req/we/addr/wdata           memory request side, held until i_mem_ack
//   i_mem_rdata, i_mem_ack            memory response
//   o_err                             watchdog abort flag (0 without ARB_TIMEOUT_EN)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW            = DEF_AW,
  parameter int unsigned DW            = DEF_DW,
  parameter int unsigned MAX_DM_STREAK = DEF_MAX_DM_STREAK,
  parameter int unsigned TIMEOUT       = DEF_TIMEOUT
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_valid,
  output logic [DW-1:0] o_if_rdata,
  input  logic          i_dm_req,
  input  logic          i_dm_we,
  input  logic [AW-1:0] i_dm_addr,
  input  logic [DW-1:0] i_dm_wdata,
  output logic          o_dm_valid,
  output logic [DW-1:0] o_dm_rdata,
  output logic          o_if_stall,
  output logic          o_dm_stall,
  output logic          o_sel,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  input  logic          i_mem_ack,
  output logic          o_err
);

  localparam int unsigned SW = $clog2(MAX_DM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

  arb_state_e    r_state, w_state_nxt;
  logic          r_sel, w_sel_nxt;
  logic          r_mem_we, w_mem_we_nxt;
  logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [SW-1:0] r_streak, w_streak_nxt;
  logic          r_if_valid, w_if_valid_nxt;
  logic          r_dm_valid, w_dm_valid_nxt;
  logic [DW-1:0] r_if_rdata, w_if_rdata_nxt;
  logic [DW-1:0] r_dm_rdata, w_dm_rdata_nxt;
  logic          w_busy;
  logic          w_timeout;

  assign w_busy = (r_state != StIdle);

  `ifdef ARB_TIMEOUT_EN
  logic r_err;

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_busy   (w_busy),
    .i_ack    (i_mem_ack),
    .o_timeout(w_timeout)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
  `else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign w_timeout        = 1'b0;
  assign o_err            = 1'b0;
  `endif

  always_comb begin
    w_state_nxt     = r_state;
    w_sel_nxt       = r_sel;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_streak_nxt    = r_streak;
    w_if_valid_nxt  = 1'b0;
    w_dm_valid_nxt  = 1'b0;
    w_if_rdata_nxt  = r_if_rdata;
    w_dm_rdata_nxt  = r_dm_rdata;

    unique case (r_state)
      StIdle: begin
        // Requests seen here during a valid cycle count as new requests.
        if (i_dm_req && (!i_if_req || (r_streak < STREAK_MAX))) begin
          w_state_nxt     = StBusyDm;
          w_sel_nxt       = SEL_DM;
          w_mem_we_nxt    = i_dm_we;
          w_mem_addr_nxt  = i_dm_addr;
          w_mem_wdata_nxt = i_dm_wdata;
          if (!i_if_req) begin
            w_streak_nxt = '0;
          end else if (r_streak != STREAK_MAX) begin
            w_streak_nxt = r_streak + SW'(1);
          end
        end else if (i_if_req) begin
          w_state_nxt     = StBusyIf;
          w_sel_nxt       = SEL_IF;
          w_mem_we_nxt    = 1'b0;
          w_mem_addr_nxt  = i_if_addr;
          w_mem_wdata_nxt = '0;
          w_streak_nxt    = '0;
        end
      end
      StBusyIf: begin
        if (i_mem_ack) begin
          w_state_nxt    = StIdle;
          w_if_valid_nxt = 1'b1;
          w_if_rdata_nxt = i_mem_rdata;
        end else if (w_timeout) begin
          w_state_nxt    = StIdle;
          w_if_valid_nxt = 1'b1;
          w_if_rdata_nxt = '0;
        end
      end
      StBusyDm: begin
        if (i_mem_ack) begin
          w_state_nxt    = StIdle;
          w_dm_valid_nxt = 1'b1;
          w_dm_rdata_nxt = i_mem_rdata;
        end else if (w_timeout) begin
          w_state_nxt    = StIdle;
          w_dm_valid_nxt = 1'b1;
          w_dm_rdata_nxt = '0;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_sel       <= SEL_IF;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_streak    <= '0;
      r_if_valid  <= 1'b0;
      r_dm_valid  <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_streak    <= w_streak_nxt;
      r_if_valid  <= w_if_valid_nxt;
      r_dm_valid  <= w_dm_valid_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_dm_rdata  <= w_dm_rdata_nxt;
    end
  end

  // mem_req is exactly "a transaction is outstanding"
  assign o_mem_req   = w_busy;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_sel       = r_sel;
  assign o_if_valid  = r_if_valid;
  assign o_dm_valid  = r_dm_valid;
  assign o_if_rdata  = r_if_rdata;
  assign o_dm_rdata  = r_dm_rdata;
  assign o_if_stall  = i_if_req & ~r_if_valid;
  assign o_dm_stall  = i_dm_req & ~r_dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_valid;
  logic [31:0] dm_rdata;
  logic        if_stall;
  logic        dm_stall;
  logic        sel;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_if_req   (if_req),
    .i_if_addr  (if_addr),
    .o_if_valid (if_valid),
    .o_if_rdata (if_rdata),
    .i_dm_req   (dm_req),
    .i_dm_we    (dm_we),
    .i_dm_addr  (dm_addr),
    .i_dm_wdata (dm_wdata),
    .o_dm_valid (dm_valid),
    .o_dm_rdata (dm_rdata),
    .o_if_stall (if_stall),
    .o_dm_stall (dm_stall),
    .o_sel      (sel),
    .o_mem_req  (mem_req),
    .o_mem_we   (mem_we),
    .o_mem_addr (mem_addr),
    .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata),
    .i_mem_ack  (mem_ack),
    .o_err      (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    // Reset state
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_sel", 64'(sel), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_valids", 64'({if_valid, dm_valid}), 64'd0);
    chk("rst_rdata", 64'({if_rdata, dm_rdata}), 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    // IF read, ack two cycles after mem_req rises
    if_req = 1'b1; if_addr = 32'h16a;
    #1;
    chk("if_stall_wait", 64'(if_stall), 64'd1);
    tick();
    chk("if_mem_req", 64'(mem_req), 64'd1);
    chk("if_sel", 64'(sel), 64'd0);
    chk("if_mem_addr", 64'(mem_addr), 64'h16a);
    chk("if_mem_we", 64'(mem_we), 64'd0);
    tick();
    chk("if_wait_req", 64'(mem_req), 64'd1);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    chk("if_no_early_valid", 64'(if_valid), 64'd0);
    tick();
    mem_ack = 1'b0;
    chk("if_valid", 64'(if_valid), 64'd1);
    chk("if_rdata", 64'(if_rdata), 64'hDEAD_BEEF);
    chk("if_req_dropped", 64'(mem_req), 64'd0);
    chk("if_stall_valid", 64'(if_stall), 64'd0);
    if_req = 1'b0;
    tick();
    chk("if_valid_pulse", 64'(if_valid), 64'd0);
    chk("if_idle", 64'(mem_req), 64'd0);
    chk("if_stall_after", 64'(if_stall), 64'd0);

    // Stray ack in IDLE is ignored
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_valids", 64'({if_valid, dm_valid}), 64'd0);
    chk("idle_ack_req", 64'(mem_req), 64'd0);
    chk("idle_ack_rdata", 64'(if_rdata), 64'hDEAD_BEEF);

    // Simultaneous requests: DM first, then IF
    if_req = 1'b1; if_addr = 32'h200; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h10f;
    tick();
    chk("sim_dm_sel", 64'(sel), 64'd1);
    chk("sim_dm_addr", 64'(mem_addr), 64'h10f);
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_0001;
    tick();
    mem_ack = 1'b0;
    chk("sim_dm_valid", 64'(dm_valid), 64'd1);
    chk("sim_dm_rdata", 64'(dm_rdata), 64'hA5A5_0001);
    dm_req = 1'b0;
    #1;
    chk("sim_if_stall", 64'(if_stall), 64'd1);
    chk("sim_dm_stall", 64'(dm_stall), 64'd0);
    tick();
    chk("sim_if_sel", 64'(sel), 64'd0);
    chk("sim_if_addr", 64'(mem_addr), 64'h200);
    chk("sim_if_req", 64'(mem_req), 64'd1);
    mem_ack = 1'b1; mem_rdata = 32'h0000_1F00;
    tick();
    mem_ack = 1'b0;
    chk("sim_if_valid", 64'(if_valid), 64'd1);
    chk("sim_if_rdata", 64'(if_rdata), 64'h0000_1F00);
    if_req = 1'b0;
    tick();

    // Starvation limit: 4 DM grants, 1 IF grant, then DM again
    if_req = 1'b1; if_addr = 32'h300; dm_req = 1'b1; dm_addr = 32'h400;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("strv_req", 64'(mem_req), 64'd1);
      chk("strv_sel", 64'(sel), (i == 4) ? 64'd0 : 64'd1);
      chk("strv_addr", 64'(mem_addr), (i == 4) ? 64'h300 : 64'h400);
      mem_ack = 1'b1; mem_rdata = 32'(i + 1);
      tick();
      mem_ack = 1'b0;
      if (i == 4) begin
        chk("strv_if_valid", 64'({if_valid, dm_valid}), 64'b10);
        chk("strv_if_rdata", 64'(if_rdata), 64'd5);
      end else begin
        chk("strv_dm_valid", 64'({if_valid, dm_valid}), 64'b01);
        chk("strv_dm_rdata", 64'(dm_rdata), 64'(i + 1));
      end
      if (i == 5) begin
        if_req = 1'b0; dm_req = 1'b0;
      end
    end
    tick();
    chk("strv_idle", 64'(mem_req), 64'd0);

    // DM write, operands held until ack
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h1234;
    tick();
    dm_wdata = 32'hFFFF_FFFF;
    chk("wr_mem_we", 64'(mem_we), 64'd1);
    chk("wr_mem_wdata", 64'(mem_wdata), 64'h1234);
    chk("wr_mem_addr", 64'(mem_addr), 64'h40);
    chk("wr_sel", 64'(sel), 64'd1);
    tick();
    chk("wr_hold_we", 64'(mem_we), 64'd1);
    chk("wr_hold_wdata", 64'(mem_wdata), 64'h1234);
    chk("wr_hold_req", 64'(mem_req), 64'd1);
    mem_ack = 1'b1; mem_rdata = 32'h0;
    tick();
    mem_ack = 1'b0;
    chk("wr_dm_valid", 64'(dm_valid), 64'd1);
    chk("wr_req_dropped", 64'(mem_req), 64'd0);
    dm_req = 1'b0; dm_we = 1'b0;
    tick();
    chk("wr_valid_pulse", 64'(dm_valid), 64'd0);

`ifdef ARB_TIMEOUT_EN
    // Watchdog abort after 64 busy cycles
    if_req = 1'b1; if_addr = 32'h55;
    tick();
    n = 0;
    while (mem_req && n < 200) begin
      n++;
      tick();
    end
    chk("wd_busy_cycles", 64'(n), 64'd64);
    chk("wd_if_valid", 64'(if_valid), 64'd1);
    chk("wd_if_rdata", 64'(if_rdata), 64'd0);
    chk("wd_err", 64'(err), 64'd1);
    if_req = 1'b0;
    tick(); tick();
    chk("wd_err_sticky", 64'(err), 64'd1);
`else
    n = 0;
    chk("no_wd_err", 64'(err), 64'(n));
`endif

    // Reset during BUSY_DM; late ack must be ignored
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
    tick();
    chk("rm_busy", 64'(mem_req), 64'd1);
    rst = 1'b1; dm_req = 1'b0;
    tick();
    rst = 1'b0;
    chk("rm_req_cleared", 64'(mem_req), 64'd0);
    chk("rm_sel", 64'(sel), 64'd0);
    chk("rm_addr", 64'(mem_addr), 64'd0);
    chk("rm_err", 64'(err), 64'd0);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    tick();
    mem_ack = 1'b0;
    chk("rm_no_valid", 64'(dm_valid), 64'd0);
    chk("rm_idle", 64'(mem_req), 64'd0);
    chk("rm_rdata", 64'(dm_rdata), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the instruction-fetch (IF) and data-memory (DM) stages of the pipelined core.
- Sequences each transaction through a small FSM and holds address and write data stable until the memory acknowledges.
- Drives the select of the external 32-bit 2:1 address/data MUX.
- Returns read data to the granted requester and produces per-stage stall signals for the hazard logic.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_DM_STREAK, 4, maximum consecutive DM grants while IF waits before IF is forced.
- TIMEOUT, 64, cycles before watchdog abort (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  IF request; held until if_valid.
- if_addr  in  AW  IF address; stable while if_req.
- if_valid  out  1  one-cycle pulse, IF data ready.
- if_rdata  out  DW  IF read data, valid with if_valid.
- dm_req  in  1  DM request; held until dm_valid.
- dm_we  in  1  DM write enable.
- dm_addr  in  AW  DM address.
- dm_wdata  in  DW  DM write data.
- dm_valid  out  1  one-cycle pulse, DM transaction done.
- dm_rdata  out  DW  DM read data (don't-care for writes).
- if_stall  out  1  if_req & ~if_valid.
- dm_stall  out  1  dm_req & ~dm_valid.
- sel  out  1  MUX select: 0 = IF, 1 = DM.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  latched address.
- mem_wdata  out  DW  latched write data.
- mem_rdata  in  DW  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion, one cycle, any latency >= 1.
- err  out  1  watchdog abort flag (tied 0 without macro).

Behaviour:
- Reset values:
  - state = IDLE.
  - mem_req, mem_we, if_valid, dm_valid, err = 0.
  - sel = 0.
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
  - streak = 0.
- FSM states: IDLE, BUSY_IF, BUSY_DM.
- IDLE arbitration:
  - Grant DM if dm_req and (~if_req or streak < MAX_DM_STREAK).
  - Else grant IF if if_req.
  - Else remain in IDLE.
  - DM wins simultaneous requests until the streak limit.
- On grant (registered, next edge):
  - state = BUSY_x; mem_req = 1; sel set.
  - mem_addr and mem_wdata latched; mem_we = dm_we for DM, 0 for IF.
- Streak counter:
  - DM grant with if_req high: streak increments, saturating.
  - DM grant with if_req low: streak clears.
  - IF grant: streak clears.
- BUSY_x:
  - mem_req and all mem_* outputs held; sel held.
  - On mem_ack: capture mem_rdata into x_rdata, pulse x_valid for the next cycle, drop mem_req, return to IDLE.
- Latency: request sampled at cycle N, mem_req high at N+1, ack at N+k (k >= 1), x_valid at N+k+1.
- A new grant is possible in the cycle x_valid is high.
  - The requester must have deasserted req by then or it is treated as a new request.
  - Requesters drop req on the edge after valid.
- mem_ack in IDLE is ignored; no valid is generated.
- sel keeps its last value in IDLE.
- Stalls are combinational from the req and valid signals.
- Reset mid-transaction: next edge forces IDLE and mem_req = 0; the in-flight result is discarded, and a later mem_ack is ignored.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in BUSY states.
  - If TIMEOUT cycles pass without mem_ack: drop mem_req, pulse x_valid with x_rdata = 0, set err (sticky until rst), return to IDLE.
- Undefined: no counter; err tied to 0; BUSY waits indefinitely.

Decomposition:
- Package mem_arb_pkg holds:
  - State enum (IDLE, BUSY_IF, BUSY_DM).
  - Select constants SEL_IF = 1'b0 and SEL_DM = 1'b1.
  - Default width constants.
- One natural sub-module, arb_watchdog: counter plus timeout compare, instantiated only under ARB_TIMEOUT_EN.

Test Plan:
- IF read only: if_req = 1, if_addr = 32'h16a, mem_ack 2 cycles after mem_req, mem_rdata = 32'hDEAD_BEEF -> sel = 0, mem_addr = 32'h16a, if_valid one cycle with if_rdata = 32'hDEAD_BEEF, if_stall low after.
- Simultaneous requests: if_req and dm_req same cycle, dm_addr = 32'h10f -> DM granted first (sel = 1, mem_addr = 32'h10f), IF served next.
- Starvation limit: dm_req held continuously with if_req high, ack latency 1 -> exactly 4 DM grants, then 1 IF grant, then DM resumes.
- DM write: dm_we = 1, dm_addr = 32'h40, dm_wdata = 32'h1234 -> mem_we = 1, mem_wdata = 32'h1234 held until ack, dm_valid pulses.
- Reset mid-transaction: rst during BUSY_DM, mem_ack arrives 2 cycles later -> mem_req 0 after reset edge, no dm_valid, state IDLE.
- With ARB_TIMEOUT_EN: no mem_ack for 64 cycles -> mem_req drops, valid pulses with rdata 0, err = 1 sticky.
